// File: rtl/multdiv_scoreboard_pkg.sv
// multdiv_scoreboard_pkg: shared pipeline constants and mult/div ownership states.
// Revision 1.0
`default_nettype none

package multdiv_scoreboard_pkg;
  localparam int REG_W    = 5;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] RSTATUS = 5'd30;

  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_DIV     = 6'h1a;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;
endpackage

`default_nettype wire

// File: rtl/multdiv_scoreboard_if.sv
// multdiv_scoreboard_if: handshake between the scoreboard and the mult/div unit.
// Revision 1.0
`default_nettype none

interface multdiv_scoreboard_if #(
  parameter int REG_W = multdiv_scoreboard_pkg::REG_W
);
  logic             multdiv_start;
  logic             multdiv_ready;
  logic             multdiv_exception;
  logic [REG_W-1:0] md_reg_D;
  logic [REG_W-1:0] md_wb_reg;
  logic             md_writeback;

  modport master (
    output multdiv_start, md_reg_D, md_wb_reg, md_writeback,
    input  multdiv_ready, multdiv_exception
  );

  modport slave (
    input  multdiv_start, md_reg_D, md_wb_reg, md_writeback,
    output multdiv_ready, multdiv_exception
  );
endinterface

`default_nettype wire

// File: rtl/multdiv_scoreboard_reg_hit_check.sv
// reg_hit_check: does the FD instruction read a valid, non-zero destination?
// Revision 1.0
`default_nettype none

module reg_hit_check #(
  parameter int REG_W = multdiv_scoreboard_pkg::REG_W
) (
  input  wire logic [REG_W-1:0] s1,
  input  wire logic [REG_W-1:0] s2,
  input  wire logic             uses1,
  input  wire logic             uses2,
  input  wire logic [REG_W-1:0] dest,
  input  wire logic             valid,
  output logic                  hit
);
  logic hit1;
  logic hit2;

  assign hit1 = uses1 & (s1 != '0) & (s1 == dest);
  assign hit2 = uses2 & (s2 != '0) & (s2 == dest);
  assign hit  = valid & (dest != '0) & (hit1 | hit2);
endmodule

`default_nettype wire

// File: rtl/multdiv_scoreboard.sv
// multdiv_scoreboard: decode-stage stall for load-use and in-flight mult/div results.
// Revision 1.0
`default_nettype none

module multdiv_scoreboard #(
  parameter int NUM_REGS   = multdiv_scoreboard_pkg::NUM_REGS,
  parameter int REG_W      = multdiv_scoreboard_pkg::REG_W,
  parameter int MD_TIMEOUT = 64
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  input  wire logic [REG_W-1:0]      fd_reg_S1,
  input  wire logic [REG_W-1:0]      fd_reg_S2,
  input  wire logic                  fd_uses_S1,
  input  wire logic                  fd_uses_S2,
  input  wire logic                  fd_is_multdiv,
  input  wire logic [REG_W-1:0]      fd_reg_D,
  input  wire logic [REG_W-1:0]      de_reg_D,
  input  wire logic                  de_is_load,
  input  wire logic                  issue,
  multdiv_scoreboard_if.master       md,
  output logic [NUM_REGS-1:0]        pending,
  output logic                       stall,
  output logic                       md_timeout,
  output multdiv_scoreboard_pkg::md_state_t md_state
);
  import multdiv_scoreboard_pkg::*;

  localparam int              CNT_W    = $clog2(MD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  md_state_t           state_q;
  md_state_t           state_d;
  logic [CNT_W-1:0]    count_q;
  logic [REG_W-1:0]    md_reg_q;
  logic [NUM_REGS-1:0] pending_q;
  logic                timeout_q;

  logic load_hit;
  logic sb_hit;
  logic struct_hit;
  logic stall_w;
  logic start_w;
  logic wb_w;
  logic term_w;

  reg_hit_check #(.REG_W(REG_W)) u_load_use (
    .s1(fd_reg_S1), .s2(fd_reg_S2), .uses1(fd_uses_S1), .uses2(fd_uses_S2),
    .dest(de_reg_D), .valid(de_is_load), .hit(load_hit)
  );

  // Only one op can be outstanding, so the owned destination is the whole lookup.
  reg_hit_check #(.REG_W(REG_W)) u_scoreboard (
    .s1(fd_reg_S1), .s2(fd_reg_S2), .uses1(fd_uses_S1), .uses2(fd_uses_S2),
    .dest(md_reg_q), .valid(pending_q[md_reg_q]), .hit(sb_hit)
  );

  assign struct_hit = fd_is_multdiv & (state_q != MD_IDLE);
  assign stall_w    = reset & (load_hit | sb_hit | struct_hit);

  always_comb begin
    state_d = state_q;
    start_w = 1'b0;
    wb_w    = 1'b0;
    term_w  = 1'b0;
    if (reset) begin
      case (state_q)
        MD_IDLE: begin
          if (issue & fd_is_multdiv & ~stall_w) begin
            start_w = 1'b1;
            state_d = MD_BUSY;
          end
        end
        MD_BUSY: begin
          // A result on the terminal count still counts as a normal completion.
          if (md.multdiv_ready) begin
            wb_w    = 1'b1;
            state_d = MD_DONE;
          end else if (count_q == CNT_LAST) begin
            term_w  = 1'b1;
            state_d = MD_IDLE;
          end
        end
        MD_DONE: state_d = MD_IDLE;
        default: state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      count_q   <= '0;
      md_reg_q  <= '0;
      pending_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_w) begin
        md_reg_q <= fd_reg_D;
        count_q  <= '0;
        if (fd_reg_D != '0) pending_q[fd_reg_D] <= 1'b1;
      end else if (state_q == MD_BUSY) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (wb_w | term_w) pending_q[md_reg_q] <= 1'b0;
      if (term_w) timeout_q <= 1'b1;
    end
  end

  assign md.multdiv_start = start_w;
  assign md.md_writeback  = wb_w;
  assign md.md_reg_D      = md_reg_q;
  assign md.md_wb_reg     = md.multdiv_exception ? REG_W'(RSTATUS) : md_reg_q;

  assign pending    = pending_q;
  assign stall      = stall_w;
  assign md_timeout = timeout_q;
  assign md_state   = state_q;
endmodule

`default_nettype wire

// File: tb/tb_multdiv_scoreboard.sv
// tb_multdiv_scoreboard: directed vectors with a per-cycle expectation queue.
// Revision 1.0
`default_nettype none

module tb_multdiv_scoreboard;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct {
    string       name;
    logic        stall;
    logic        start;
    logic        wb;
    logic [4:0]  wbreg;
    logic [31:0] pend;
    logic        tmo;
    logic [1:0]  st;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  fd_reg_S1, fd_reg_S2, fd_reg_D, de_reg_D;
  logic        fd_uses_S1, fd_uses_S2, fd_is_multdiv, de_is_load, issue;
  logic [31:0] pending;
  logic        stall, md_timeout;
  logic [1:0]  md_state;

  int   total = 0;
  int   bad   = 0;
  exp_t expq[$];

  multdiv_scoreboard_if #(.REG_W(5)) mdif ();

  multdiv_scoreboard #(.NUM_REGS(32), .REG_W(5), .MD_TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .fd_reg_S1(fd_reg_S1), .fd_reg_S2(fd_reg_S2),
    .fd_uses_S1(fd_uses_S1), .fd_uses_S2(fd_uses_S2),
    .fd_is_multdiv(fd_is_multdiv), .fd_reg_D(fd_reg_D),
    .de_reg_D(de_reg_D), .de_is_load(de_is_load), .issue(issue),
    .md(mdif), .pending(pending), .stall(stall),
    .md_timeout(md_timeout), .md_state(md_state)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s got=%h want=%h", nm, fld, act, want);
    end
  endfunction

  task automatic drive(input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic ismd,
                       input logic [4:0] fdd, input logic [4:0] ded,
                       input logic ld, input logic iss,
                       input logic rdy, input logic exc);
    fd_reg_S1 = s1; fd_reg_S2 = s2; fd_uses_S1 = u1; fd_uses_S2 = u2;
    fd_is_multdiv = ismd; fd_reg_D = fdd; de_reg_D = ded; de_is_load = ld;
    issue = iss; mdif.multdiv_ready = rdy; mdif.multdiv_exception = exc;
  endtask

  task automatic idle_in();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc(input string nm, input logic e_stall, input logic e_start,
                     input logic e_wb, input logic [4:0] e_wbreg,
                     input logic [31:0] e_pend, input logic e_tmo,
                     input logic [1:0] e_st);
    exp_t e;
    e.name = nm; e.stall = e_stall; e.start = e_start; e.wb = e_wb;
    e.wbreg = e_wbreg; e.pend = e_pend; e.tmo = e_tmo; e.st = e_st;
    expq.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk(e.name, "stall", {31'd0, stall}, {31'd0, e.stall});
        chk(e.name, "start", {31'd0, mdif.multdiv_start}, {31'd0, e.start});
        chk(e.name, "wb", {31'd0, mdif.md_writeback}, {31'd0, e.wb});
        if (e.wb) chk(e.name, "wbreg", {27'd0, mdif.md_wb_reg}, {27'd0, e.wbreg});
        chk(e.name, "pending", pending, e.pend);
        chk(e.name, "timeout", {31'd0, md_timeout}, {31'd0, e.tmo});
        chk(e.name, "state", {30'd0, md_state}, {30'd0, e.st});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Held in reset: hazards present but every combinational output stays low.
    drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    reset = 1'b1;

    // Load-use: lw r5 in DE, add r6,r5,r1 in FD.
    drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("loaduse", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("loaduse_nop", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("loaduse_r0", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("loaduse_s2", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("loaduse_unused", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);

    // mul r7, consumer of r7 waits through the ready cycle.
    drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mul7_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul7_busy0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 1'b0, S_BUSY);
    cyc("mul7_busy1", 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b1;
    cyc("mul7_ready", 1'b1, 1'b0, 1'b1, 5'd7, 32'h80, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b0; issue = 1'b1;
    cyc("mul7_done", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_DONE);
    idle_in();
    cyc("mul7_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);

    // mul r8 busy while mul r9 waits in FD; r9 then ends with divide-by-zero.
    drive(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mul8_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul9_wait_busy", 1'b1, 1'b0, 1'b0, 5'd0, 32'h100, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b1;
    cyc("mul8_ready", 1'b1, 1'b0, 1'b1, 5'd8, 32'h100, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b0;
    cyc("mul9_wait_done", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_DONE);
    issue = 1'b1;
    cyc("mul9_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    idle_in();
    cyc("div9_busy", 1'b0, 1'b0, 1'b0, 5'd0, 32'h200, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b1; mdif.multdiv_exception = 1'b1;
    cyc("div9_exc", 1'b0, 1'b0, 1'b1, 5'd30, 32'h200, 1'b0, S_BUSY);
    idle_in();
    cyc("div9_done", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_DONE);
    cyc("div9_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);

    // Ready arriving on the terminal count wins over the timeout.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mul3_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    idle_in();
    for (int i = 0; i < 7; i++)
      cyc("mul3_busy", 1'b0, 1'b0, 1'b0, 5'd0, 32'h8, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b1;
    cyc("mul3_ready_last", 1'b0, 1'b0, 1'b1, 5'd3, 32'h8, 1'b0, S_BUSY);
    idle_in();
    cyc("mul3_done", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_DONE);
    cyc("mul3_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);

    // Timeout: mul r4 never completes.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mul4_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    drive(5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul4_read", 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 1'b0, S_BUSY);
    idle_in();
    for (int i = 1; i < 8; i++)
      cyc("mul4_busy", 1'b0, 1'b0, 1'b0, 5'd0, 32'h10, 1'b0, S_BUSY);
    mdif.multdiv_ready = 1'b1;
    cyc("mul4_late_ready", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, S_IDLE);
    idle_in();
    cyc("mul4_sticky", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, S_IDLE);

    // Reset mid-BUSY discards everything, including the later result.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("mul6_start", 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, S_IDLE);
    drive(5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mul6_busy", 1'b1, 1'b0, 1'b0, 5'd0, 32'h40, 1'b1, S_BUSY);
    reset = 1'b0;
    cyc("mul6_in_reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h40, 1'b1, S_BUSY);
    reset = 1'b1; mdif.multdiv_ready = 1'b1;
    cyc("mul6_after_reset", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);
    idle_in();
    cyc("final_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, S_IDLE);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clock);
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/multdiv_scoreboard.md
Name: multdiv_scoreboard

Overview:
- Tracks destination registers with writes still in flight and produces the decode-stage stall.
- Covers the two cases that forwarding cannot resolve: load-use, and results from the multi-cycle mult/div unit.
- Sits beside the decode-stage bypass selector. The selector routes values that already exist; this block holds FD/DE until the value exists.
- Contains the mult/div ownership FSM and a pending-write bit per architectural register.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 never pending.
- REG_W, 5, register index width.
- MD_TIMEOUT, 64, maximum cycles from mult/div issue to result before abort.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset.
- fd_reg_S1  in  REG_W  FD source register 1.
- fd_reg_S2  in  REG_W  FD source register 2.
- fd_uses_S1  in  1  FD instruction reads S1.
- fd_uses_S2  in  1  FD instruction reads S2.
- fd_is_multdiv  in  1  FD instruction is mul/div.
- de_reg_D  in  REG_W  DE destination.
- de_is_load  in  1  DE instruction is lw.
- issue  in  1  FD instruction advances into DE this cycle (qualified by ~stall upstream).
- multdiv_start  out  1  one-cycle start pulse to mult/div unit.
- multdiv_ready  in  1  mult/div result valid this cycle.
- multdiv_exception  in  1  mult/div divide-by-zero; valid with multdiv_ready.
- md_reg_D  out  REG_W  destination owned by current mult/div op.
- md_writeback  out  1  writeback port must take mult/div result this cycle.
- pending  out  NUM_REGS  pending-write bit vector.
- stall  out  1  freeze PC/FD, inject nop into DE.
- md_timeout  out  1  sticky abort flag.

Behaviour:
- Reset (reset==0 at posedge): state IDLE, pending=0, counter=0, md_reg_D=0, md_timeout=0. Combinational outputs multdiv_start, md_writeback and stall are 0 while in reset.
- Hit: hitN = fd_usesN & (fd_reg_SN != 0). Index 0 is never compared and never pending.
- Load-use stall: de_is_load & de_reg_D!=0 & (hit1 & S1==de_reg_D | hit2 & S2==de_reg_D). Always exactly one cycle, because DE then receives a nop.
- Scoreboard stall: hit1 & pending[S1] | hit2 & pending[S2].
- Structural stall: fd_is_multdiv & state!=IDLE.
- stall is the OR of the three stall terms.
- Instruction destination comes from the FD-stage decoder, registered in the same cycle as issue.
- FSM IDLE:
  - issue & fd_is_multdiv & ~stall → multdiv_start=1 (combinational, same cycle).
  - Next: md_reg_D <= FD destination; pending[dest] <= 1 if dest!=0; counter <= 0; state BUSY.
- FSM BUSY:
  - counter increments each cycle.
  - multdiv_ready → md_writeback=1 same cycle; pending[md_reg_D] <= 0; state DONE.
  - multdiv_exception forces the write target to $rstatus (r30). md_reg_D remains the original destination, and its pending bit is still cleared.
  - counter==MD_TIMEOUT-1 without ready → pending[md_reg_D] <= 0; md_timeout <= 1; state IDLE.
- FSM DONE: one cycle, lets the clearing propagate; → IDLE. A mult/div in FD stalls during DONE.
- Simultaneous ready and FD read of md_reg_D: stall still asserted that cycle, since pending clears at the edge. Next cycle the value is forwarded through the writeback path.
- Simultaneous ready and timeout terminal count: ready wins; md_timeout not set.
- Reset during BUSY: all state discarded. The unit's later multdiv_ready is ignored in IDLE, with no writeback.
- Only one pending bit can be set at a time. The vector is kept for debug and for future multiple outstanding ops.
- md_timeout cleared only by reset.

Decomposition:
- Shared pipeline package: REG_W, NUM_REGS, RSTATUS=5'd30, opcode constants for lw/mul/div (used by the destination decoder), and a 2-bit FSM state encoding (IDLE=0, BUSY=1, DONE=2).
- Sub-module: reg_hit_check. Given S1/S2, uses, a destination and a valid bit, returns hit. Instantiated for load-use and scoreboard lookups.
- Scoreboard vector and FSM stay in the top module.

Test Plan:
- lw r5 in DE; FD add r6,r5,r1 → stall=1 exactly one cycle, then 0. lw r0 in DE with FD reading r0 → stall=0.
- mul r7 issues in IDLE → multdiv_start pulse 1 cycle; pending[7]=1. FD reading r7 stalls until the cycle after multdiv_ready. md_writeback=1 with md_reg_D=7 in the ready cycle.
- Second mul in FD while BUSY → stall held through BUSY and DONE; start issued the first IDLE cycle, exactly one start pulse.
- div with multdiv_exception at ready → md_writeback=1, write target r30; pending[original dest] cleared.
- MD_TIMEOUT=8, ready never asserted → at cycle 8 after start: pending cleared, md_timeout=1, state IDLE. Late multdiv_ready → no md_writeback.
- reset low mid-BUSY → next cycle pending=0, stall=0, state IDLE; following ready ignored.
